// File: rtl/datapath_regfile_pkg.sv
// Shared register-file definitions: sizes, the link register index and the index type.
// Imported by the register file and by its in-flight write scoreboard.
package datapath_regfile_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_LINK = 3'd7;

    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = {SB_CNT_W{1'b1}};

endpackage

// File: rtl/datapath_regfile_scoreboard.sv
// In-flight write scoreboard: per-register outstanding-write counters, hazard stall
// for decode, and a sticky error flag for retires that find no reservation.
module datapath_regfile_scoreboard
    import datapath_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     retire_valid,
    input  reg_idx_t retire_reg,
    input  reg_idx_t rd_addr1,
    input  reg_idx_t rd_addr2,
    input  logic     issue_valid,
    input  logic     issue_src1,
    input  logic     issue_src2,
    input  logic     issue_writes,
    input  reg_idx_t issue_dst,
    output logic     stall,
    output logic     sb_err
);

    logic [SB_CNT_W-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0] fire_hit;
    logic [NUM_REGS-1:0] ret_hit;
    logic [NUM_REGS-1:0] pend;
    logic                fire;
    logic                full;
    logic                err_now;

    // A same-cycle retire is subtracted before testing, so it releases the hazard at once.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ret_hit[r] = retire_valid && (retire_reg == reg_idx_t'(r));
            pend[r]    = (cnt[r] - {{(SB_CNT_W-1){1'b0}}, ret_hit[r]}) != '0;
        end
    end

    always_comb begin
        full  = issue_writes && (cnt[issue_dst] == SB_CNT_MAX) && !ret_hit[issue_dst];
        stall = issue_valid && ((issue_src1 && pend[rd_addr1]) ||
                                (issue_src2 && pend[rd_addr2]) || full);
        fire  = issue_valid && !stall && issue_writes;
        err_now = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            fire_hit[r] = fire && (issue_dst == reg_idx_t'(r));
            if (ret_hit[r] && !fire_hit[r] && (cnt[r] == '0))
                err_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (fire_hit[r] && !ret_hit[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (ret_hit[r] && !fire_hit[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (err_now)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/datapath_regfile.sv
// Architectural register file with write-before-read bypass on both decode read ports,
// wrapped around the in-flight write scoreboard that produces the decode hazard stall.
module datapath_regfile
    import datapath_regfile_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RFWrite,
    input  logic [DATA_W-1:0] dataw,
    input  reg_idx_t          regw,
    input  logic              retire_valid,
    input  reg_idx_t          retire_reg,
    input  reg_idx_t          rd_addr1,
    input  reg_idx_t          rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              issue_valid,
    input  logic              issue_src1,
    input  logic              issue_src2,
    input  logic              issue_writes,
    input  reg_idx_t          issue_dst,
    output logic              stall,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (RFWrite) begin
            regs[regw] <= dataw;
        end
    end

    // Writeback data is forwarded so decode sees the value being written this cycle.
    always_comb begin
        rd_data1 = (RFWrite && (regw == rd_addr1)) ? dataw : regs[rd_addr1];
        rd_data2 = (RFWrite && (regw == rd_addr2)) ? dataw : regs[rd_addr2];
    end

    datapath_regfile_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_reg   (retire_reg),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .issue_valid  (issue_valid),
        .issue_src1   (issue_src1),
        .issue_src2   (issue_src2),
        .issue_writes (issue_writes),
        .issue_dst    (issue_dst),
        .stall        (stall),
        .sb_err       (sb_err)
    );

endmodule
